// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: default widths, bus command encoding
// and the round-robin pick helper.
package bus_pkg;
  localparam int AW_DEF  = 16;
  localparam int DW_DEF  = 16;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo n (n <= MAX_REQ).
  // Scanning from the farthest position down lets the nearest one win.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int                 n);
    rr_pick_t       res;
    logic [IDX_W:0] pos;
    res = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        pos = {1'b0, ptr} + (IDX_W+1)'(k);
        if (pos >= (IDX_W+1)'(n)) pos = pos - (IDX_W+1)'(n);
        if (req[pos[IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick with a registered favour pointer; the pointer
// only moves past a winner when the grant is actually issued.
import bus_pkg::*;

module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_bus,
  input  logic             rst_bus,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    winner,
  output logic             found
);
  logic [IW-1:0]      rr_ptr;
  logic [MAX_REQ-1:0] req_ext;
  logic [IDX_W-1:0]   ptr_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    ptr_ext              = '0;
    ptr_ext[IW-1:0]      = rr_ptr;
    pick                 = rr_pick(req_ext, ptr_ext, N_REQ);
  end

  assign found  = pick.found && ({1'b0, pick.idx} < (IDX_W+1)'(N_REQ));
  assign winner = pick.idx[IW-1:0];

  always_comb begin
    gnt = '0;
    if (found && advance) gnt[winner] = 1'b1;
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      rr_ptr <= '0;
    end else if (found && advance) begin
      rr_ptr <= (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Shares the memory bus between the CPU (absolute priority, no stall) and
// N secondary masters served round-robin, with tagged one-cycle read return.
import bus_pkg::*;

module bus_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk_bus,
  input  logic                rst_bus,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_dout,
  input  logic                cpu_write,
  input  logic                cpu_read,
  output logic [DW-1:0]       cpu_din,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DW-1:0]       mem_rdata
);
  logic          cpu_cycle;
  logic          found;
  logic [IW-1:0] winner;
  logic          rd_pend;
  logic [IW-1:0] rd_id;
  logic          cpu_rd_pend;
  bus_cmd_e      cmd;

  assign cpu_cycle = cpu_read | cpu_write;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_bus (clk_bus),
    .rst_bus (rst_bus),
    .req     (req),
    .advance (~cpu_cycle),
    .gnt     (gnt),
    .winner  (winner),
    .found   (found)
  );

  always_comb begin
    cmd       = CMD_IDLE;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_cycle) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      cmd       = cpu_write ? CMD_WR : CMD_RD;
    end else if (found) begin
      mem_addr  = req_addr[int'(winner)*AW +: AW];
      mem_wdata = req_wdata[int'(winner)*DW +: DW];
      cmd       = req_we[winner] ? CMD_WR : CMD_RD;
    end
  end

  assign mem_we = (cmd == CMD_WR);
  assign mem_re = (cmd == CMD_RD);

  // Return routing uses only the registered tag, so a CPU cycle on the
  // return beat cannot misdirect the data.
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      rd_pend     <= 1'b0;
      rd_id       <= '0;
      cpu_rd_pend <= 1'b0;
    end else begin
      rd_pend     <= !cpu_cycle && found && !req_we[winner];
      if (!cpu_cycle && found) rd_id <= winner;
      cpu_rd_pend <= cpu_cycle && mem_re;
    end
  end

  always_comb begin
    rvalid        = '0;
    rvalid[rd_id] = rd_pend;
  end

  assign rdata   = mem_rdata;
  assign cpu_din = mem_rdata;

  a_single_return: assert property (@(posedge clk_bus) disable iff (!rst_bus)
                                    !(rd_pend && cpu_rd_pend));
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed table, hand sequences and
// randomized traffic against a rule-level reference model.
module tb_bus_arbiter;
  localparam int N = 4;

  logic          clk_bus = 1'b0;
  logic          rst_bus;
  logic [15:0]   cpu_addr, cpu_dout, cpu_din;
  logic          cpu_write, cpu_read;
  logic [N-1:0]  req, req_we, gnt, rvalid;
  logic [N*16-1:0] req_addr, req_wdata;
  logic [15:0]   rdata, mem_addr, mem_wdata, mem_rdata;
  logic          mem_we, mem_re;

  bus_arbiter #(.N_REQ(N), .AW(16), .DW(16)) dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_write(cpu_write),
    .cpu_read(cpu_read), .cpu_din(cpu_din),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk_bus = ~clk_bus;

  logic [15:0] bus_mem [65536];
  logic [15:0] ref_mem [65536];

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_ptr;
  bit          m_pend;
  int          m_pend_id;
  logic [15:0] m_pend_data;
  bit          m_cpu_pend;
  logic [15:0] m_cpu_data;

  typedef struct {
    bit          crd, cwr;
    logic [15:0] caddr, cdout;
    logic [3:0]  rq, rwe;
    logic [3:0]  e_gnt;
    bit          e_we, e_re;
    logic [15:0] e_addr, e_wdata;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_m(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    req_we[i]           = we;
    req_addr[i*16 +: 16]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic idle_in();
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_dout = '0;
    req = '0; req_we = '0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_cpu_pend = 0;
  endtask

  // One bus cycle: entered just after a negedge with inputs applied.
  task automatic cycle();
    logic [3:0]  e_gnt, e_rv;
    logic        e_we, e_re, c_we, c_re, cpu_act;
    logic [15:0] e_addr, e_wdata, c_addr, c_wdata;
    int          w;
    #1;
    e_gnt = '0; e_we = 0; e_re = 0; e_addr = '0; e_wdata = '0; w = -1;
    cpu_act = cpu_read || cpu_write;
    if (cpu_act) begin
      e_addr = cpu_addr; e_wdata = cpu_dout;
      e_we = cpu_write; e_re = cpu_read && !cpu_write;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && req[i]) w = i;
      end
      if (w >= 0) begin
        e_gnt[w] = 1'b1;
        e_addr   = req_addr[w*16 +: 16];
        e_wdata  = req_wdata[w*16 +: 16];
        e_we     = req_we[w];
        e_re     = !req_we[w];
      end
    end
    e_rv = m_pend ? (4'b0001 << m_pend_id) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    if (m_pend) chk("rdata", 32'(rdata), 32'(m_pend_data));
    if (m_cpu_pend) chk("cpu_din", 32'(cpu_din), 32'(m_cpu_data));
    c_we = mem_we; c_re = mem_re; c_addr = mem_addr; c_wdata = mem_wdata;
    @(posedge clk_bus);
    if (c_we) bus_mem[c_addr] = c_wdata;
    mem_rdata = c_re ? bus_mem[c_addr] : 16'($urandom);
    m_pend     = (w >= 0) && !req_we[w];
    m_cpu_pend = cpu_act && e_re;
    if (m_pend) begin m_pend_id = w; m_pend_data = ref_mem[e_addr]; end
    if (m_cpu_pend) m_cpu_data = ref_mem[e_addr];
    if (e_we) ref_mem[e_addr] = e_wdata;
    if (w >= 0) m_ptr = (w + 1) % N;
    @(negedge clk_bus);
  endtask

  task automatic do_reset();
    rst_bus = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    model_reset();
    @(negedge clk_bus);
    rst_bus = 1'b1;
  endtask

  initial begin
    logic [3:0] rr_exp[5];
    int gap;
    for (int a = 0; a < 65536; a++) begin
      bus_mem[a] = 16'(a) ^ 16'hA5C3;
      ref_mem[a] = 16'(a) ^ 16'hA5C3;
    end
    tbl[0]  = '{0,0,16'h0000,16'h0000,4'b0000,4'b0000, 4'b0000,0,0,16'h0000,16'h0000};
    tbl[1]  = '{0,1,16'h0040,16'hBEEF,4'b0001,4'b0000, 4'b0000,1,0,16'h0040,16'hBEEF};
    tbl[2]  = '{0,0,16'h0000,16'h0000,4'b0001,4'b0000, 4'b0001,0,1,16'h1000,16'hA000};
    tbl[3]  = '{0,0,16'h0000,16'h0000,4'b1111,4'b0000, 4'b0010,0,1,16'h1010,16'hA001};
    tbl[4]  = '{1,1,16'h0010,16'h1234,4'b1111,4'b0000, 4'b0000,1,0,16'h0010,16'h1234};
    tbl[5]  = '{0,0,16'h0000,16'h0000,4'b1111,4'b0100, 4'b0100,1,0,16'h1020,16'hA002};
    tbl[6]  = '{0,0,16'h0000,16'h0000,4'b1000,4'b0000, 4'b1000,0,1,16'h1030,16'hA003};
    tbl[7]  = '{0,0,16'h0000,16'h0000,4'b0110,4'b0000, 4'b0010,0,1,16'h1010,16'hA001};
    tbl[8]  = '{0,0,16'h0000,16'h0000,4'b0110,4'b0000, 4'b0100,0,1,16'h1020,16'hA002};
    tbl[9]  = '{0,0,16'h0000,16'h0000,4'b0101,4'b0000, 4'b0001,0,1,16'h1000,16'hA000};
    tbl[10] = '{1,0,16'h0200,16'h0000,4'b0101,4'b0000, 4'b0000,0,1,16'h0200,16'h0000};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_bus = 1'b0; mem_rdata = '0; req_addr = '0; req_wdata = '0;
    idle_in();
    model_reset();
    @(negedge clk_bus);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_we_re", {30'h0, mem_we, mem_re}, 32'h0);
    chk("rst_rvalid0", 32'(rvalid), 32'h0);
    @(negedge clk_bus);
    rst_bus = 1'b1;

    // directed table
    for (int r = 0; r < 11; r++) begin
      cpu_read = tbl[r].crd; cpu_write = tbl[r].cwr;
      cpu_addr = tbl[r].caddr; cpu_dout = tbl[r].cdout;
      req = tbl[r].rq;
      for (int i = 0; i < N; i++)
        set_m(i, tbl[r].rwe[i], 16'h1000 + 16'(i*16), 16'hA000 + 16'(i));
      #1;
      chk("tbl_gnt", 32'(gnt), 32'(tbl[r].e_gnt));
      chk("tbl_we", 32'(mem_we), 32'(tbl[r].e_we));
      chk("tbl_re", 32'(mem_re), 32'(tbl[r].e_re));
      chk("tbl_addr", 32'(mem_addr), 32'(tbl[r].e_addr));
      chk("tbl_wdata", 32'(mem_wdata), 32'(tbl[r].e_wdata));
      cycle();
    end
    idle_in(); cycle();

    // round-robin with all four reading
    do_reset();
    idle_in();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 16'h0300 + 16'(i), 16'h0);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1 chk("rr_seq", 32'(gnt), 32'(rr_exp[c]));
      cycle();
    end
    idle_in(); cycle();

    // CPU reads every other cycle, masters 1 and 2 fill the gaps
    do_reset();
    idle_in();
    set_m(1, 1'b0, 16'h0021, 16'h0); set_m(2, 1'b0, 16'h0022, 16'h0);
    gap = 0;
    for (int c = 0; c < 8; c++) begin
      cpu_read = (c % 2 == 0); cpu_addr = 16'h0050 + 16'(c);
      req = 4'b0110;
      #1;
      if (cpu_read) chk("gap_cpu_gnt", 32'(gnt), 32'h0);
      else begin
        chk("gap_gnt", 32'(gnt), (gap % 2 == 0) ? 32'h2 : 32'h4);
        gap++;
      end
      cycle();
    end
    idle_in(); cycle();

    // both CPU strobes: write wins, read back later
    cpu_read = 1; cpu_write = 1; cpu_addr = 16'h0010; cpu_dout = 16'h1234;
    #1 chk("both_we_re", {30'h0, mem_we, mem_re}, 32'h2);
    cycle();
    cpu_write = 0; cycle();
    idle_in();
    #1 chk("both_readback", 32'(cpu_din), 32'h1234);
    cycle();

    // master 2 writes, master 3 reads it back, pointer wraps to 0
    do_reset();
    idle_in();
    set_m(2, 1'b1, 16'h0100, 16'h5555); req = 4'b0100; cycle();
    req_we = '0; set_m(3, 1'b0, 16'h0100, 16'h0); req = 4'b1000; cycle();
    for (int i = 0; i < N; i++) set_m(i, 1'b0, 16'h0400 + 16'(i), 16'h0);
    req = 4'b1111;
    #1;
    chk("m3_rvalid", 32'(rvalid), 32'h8);
    chk("m3_rdata", 32'(rdata), 32'h5555);
    chk("wrap_gnt", 32'(gnt), 32'h1);
    cycle();

    // reset while a read return is pending
    idle_in();
    #1 chk("pre_rst_rvalid", 32'(rvalid), 32'h1);
    do_reset();
    idle_in(); cycle();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      cpu_read  = ($urandom_range(0, 9) < 3);
      cpu_write = ($urandom_range(0, 9) < 2);
      cpu_addr  = 16'($urandom_range(0, 63));
      cpu_dout  = 16'($urandom);
      req = 4'($urandom);
      for (int i = 0; i < N; i++)
        set_m(i, 1'($urandom), 16'($urandom_range(0, 63)), 16'($urandom));
      cycle();
    end
    idle_in(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single data-memory/peripheral bus port between the CPU load/store path and N secondary bus masters (DMA, UART block mover, debug port).
- The CPU has no stall input, so it always has absolute priority. Secondary masters get only the cycles in which the CPU is not reading or writing.
- Secondary masters are served round-robin through a req/gnt handshake. Read data returns one cycle later with a per-master valid strobe.
- Sits between the CPU bus pins (Addr/Dout/Din/read/write) and the memory-mapped bus.

Parameters:
- N_REQ, 4, number of secondary masters (2..8).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk_bus  in  1  system clock; all state updates on rising edge.
- rst_bus  in  1  reset, asynchronous, active-low.
- cpu_addr  in  AW  CPU bus address.
- cpu_dout  in  DW  CPU write data.
- cpu_write  in  1  CPU write strobe.
- cpu_read  in  1  CPU read strobe.
- cpu_din  out  DW  read data to CPU.
- req  in  N_REQ  per-master request; held until granted.
- req_we  in  N_REQ  per-master write (1) / read (0).
- req_addr  in  N_REQ*AW  packed addresses; master i at [i*AW +: AW].
- req_wdata  in  N_REQ*DW  packed write data.
- gnt  out  N_REQ  one-hot grant; the transfer happens in the gnt cycle.
- rvalid  out  N_REQ  one-hot read-return strobe.
- rdata  out  DW  read-return data for secondary masters.
- mem_addr  out  AW  bus address.
- mem_wdata  out  DW  bus write data.
- mem_we  out  1  bus write enable.
- mem_re  out  1  bus read enable.
- mem_rdata  in  DW  bus read data, valid one cycle after mem_re.

Behaviour:
- State:
  - rr_ptr[log2 N_REQ] (next master to favour).
  - rd_pend (1 bit).
  - rd_id[log2 N_REQ].
  - cpu_rd_pend (1 bit).
- Reset (rst_bus=0, async): rr_ptr=0, rd_pend=0, cpu_rd_pend=0, so rvalid=0 immediately. Combinational outputs follow their inputs.
- Owner selection, combinational, every cycle:
  - CPU cycle if cpu_read|cpu_write:
    - mem_addr=cpu_addr, mem_wdata=cpu_dout, mem_we=cpu_write, mem_re=cpu_read&~cpu_write, gnt=0.
    - If both strobes are high, the write wins.
  - Else if |req: winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … mod N_REQ.
    - gnt[winner]=1, mem_addr/mem_wdata from that master's slice.
    - mem_we=req_we[winner], mem_re=~req_we[winner].
  - Else idle: mem_we=mem_re=0, mem_addr=0, mem_wdata=0, gnt=0.
- Round-robin update: on a grant, rr_ptr <= (winner+1) mod N_REQ. rr_ptr is unchanged in CPU and idle cycles.
- Handshake:
  - A master keeps req, req_we, req_addr and req_wdata stable until it samples gnt=1.
  - It may drop req or present a new request in the cycle after gnt.
  - A req deasserted before grant is simply not served.
- Read return, latency 1:
  - On a granted secondary read: rd_pend<=1, rd_id<=winner. Otherwise rd_pend<=0.
  - rvalid[rd_id]=rd_pend and rdata=mem_rdata in the following cycle.
  - Back-to-back reads from the same or different masters produce consecutive rvalid pulses, each correctly tagged.
- CPU read: cpu_rd_pend<=mem_re in a CPU cycle. cpu_din=mem_rdata unconditionally (passthrough), so the CPU sees its data the cycle after the read.
- A secondary-read return in cycle t+1 is not disturbed if the CPU takes cycle t+1. Only port ownership changes; return routing comes from the registered tag.
- Starvation: secondaries wait indefinitely while the CPU is busy every cycle. This is documented, not an error.
- Reset mid-read: the pending rvalid is dropped and the master must re-request.

Decomposition:
- Shared package `bus_pkg`: AW/DW defaults, the bus command encoding (IDLE/RD/WR), and a function `rr_pick(req, ptr)` returning the winner index and a found flag.
- One natural sub-module: `rr_arbiter` (combinational round-robin pick plus registered rr_ptr). It is reusable for the interrupt-source scheduler.

Test Plan:
- Reset, then no activity: mem_we=mem_re=0, gnt=0, rvalid=0. Assert rst_bus low mid-read: rvalid clears immediately.
- CPU write addr 0x0040 data 0xBEEF while req=4'b0001: mem_we=1, mem_addr=0x0040, gnt=0. The next idle cycle gives gnt=4'b0001 with master 0's address.
- req=4'b1111 held, all reads, CPU idle: grants go 0,1,2,3,0 on consecutive cycles. rvalid follows one cycle later with the same sequence, and rdata equals the memory model's value at each address.
- CPU reads every other cycle and req=4'b0110: secondaries are granted only in the gap cycles, alternating 1,2. cpu_din carries the CPU's read data the cycle after each CPU read.
- cpu_read=cpu_write=1 at 0x0010 data 0x1234: mem_we=1, mem_re=0, and memory holds 0x1234 afterwards.
- Master 2 write 0x5555 to 0x0100, then master 3 reads 0x0100 on the next free cycle: rvalid=4'b1000 with rdata=0x5555. rr_ptr is 0 after master 3's grant.
